force_override_bank: RTL

//  Responder side of the force/release protocol: a bank of DEPTH registers that accepts

---
 rtl/force_bank_pkg.sv | 22 ++
 rtl/force_bank_entry.sv | 97 +++++++++
 rtl/force_override_bank.sv | 110 +++++++++++
 3 files changed

// File: rtl/force_bank_pkg.sv
// force_bank_pkg
//  Shared types for the force/release register bank.
//  op_e           : command opcode carried on cmd_op
//  entry_state_e  : per-entry override state
//  IGN_CNT_W      : width of the dropped-write statistics counter
package force_bank_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_WRITE   = 2'd1,
    OP_FORCE   = 2'd2,
    OP_RELEASE = 2'd3
  } op_e;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_FORCED = 1'b1
  } entry_state_e;

  localparam int IGN_CNT_W = 8;

endpackage

// File: rtl/force_bank_entry.sv
// force_bank_entry
//  One overridable register: FREE/FORCED state machine plus stored value.
//  Optional macro FORCE_BANK_SHADOW_EN adds a shadow register that tracks every
//  WRITE; RELEASE then restores the shadow (net-style release). Without it a
//  RELEASE keeps the forced value (variable-style release).
// Ports
//  clk, rst_n   clock / asynchronous active-low reset
//  sel          this entry is the target of an accepted command
//  op           command opcode (op_e encoding)
//  data         command data
//  value        current stored value
//  value_next   value after the current edge (feeds same-edge readback)
//  forced       entry is in the FORCED state
//  drop_pulse   accepted WRITE was ignored because the entry is forced
//  err_pulse    accepted RELEASE hit an entry that was not forced
module force_bank_entry
  import force_bank_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = 'h666
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_next,
  output logic             forced,
  output logic             drop_pulse,
  output logic             err_pulse
);

  entry_state_e     state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
`ifdef FORCE_BANK_SHADOW_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
`endif

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    drop_pulse = 1'b0;
    err_pulse  = 1'b0;
`ifdef FORCE_BANK_SHADOW_EN
    shadow_d   = shadow_q;
`endif
    if (sel) begin
      case (op_e'(op))
        OP_WRITE: begin
`ifdef FORCE_BANK_SHADOW_EN
          // Shadow follows the procedural value even while overridden.
          shadow_d = data;
`endif
          if (state_q == ST_FREE) value_d = data;
          else                    drop_pulse = 1'b1;
        end
        OP_FORCE: begin
          value_d = data;
          state_d = ST_FORCED;
        end
        OP_RELEASE: begin
          if (state_q == ST_FORCED) begin
            state_d = ST_FREE;
`ifdef FORCE_BANK_SHADOW_EN
            value_d = shadow_q;
`endif
          end else begin
            err_pulse = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FREE;
      value_q  <= RESET_VAL;
`ifdef FORCE_BANK_SHADOW_EN
      shadow_q <= RESET_VAL;
`endif
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
`ifdef FORCE_BANK_SHADOW_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign value      = value_q;
  assign value_next = value_d;
  assign forced     = (state_q == ST_FORCED);

endmodule

// File: rtl/force_override_bank.sv
// force_override_bank
//  Responder for the force/release protocol: DEPTH overridable registers
//  driven by WRITE / FORCE / RELEASE commands over a valid/ready port.
//  Optional macro FORCE_BANK_SHADOW_EN selects net-style release (see
//  force_bank_entry).
// Ports
//  clk, rst_n    clock / asynchronous active-low reset
//  cmd_valid     command present
//  cmd_ready     bank can accept (low for the cycle after an accepted RELEASE)
//  cmd_op        opcode: NOP=0, WRITE=1, FORCE=2, RELEASE=3
//  cmd_addr      target entry
//  cmd_data      data for WRITE / FORCE
//  rd_addr       readback select
//  rd_data       registered readback (0 for out-of-range rd_addr)
//  forced_mask   bit i set while entry i is forced
//  ign_cnt       saturating count of WRITEs dropped on forced entries
//  cmd_err       one-cycle pulse: bad address or RELEASE of an unforced entry
module force_override_bank
  import force_bank_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter int               AW        = $clog2(DEPTH > 1 ? DEPTH : 2),
  parameter logic [WIDTH-1:0] RESET_VAL = 'h666
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [WIDTH-1:0]     cmd_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic [DEPTH-1:0]     forced_mask,
  output logic [IGN_CNT_W-1:0] ign_cnt,
  output logic                 cmd_err
);

  logic                 accept;
  logic [DEPTH-1:0]     addr_hit;
  logic [DEPTH-1:0]     drop_vec;
  logic [DEPTH-1:0]     err_vec;
  logic [WIDTH-1:0]     value_vec  [DEPTH];
  logic [WIDTH-1:0]     value_next [DEPTH];

  logic                 cmd_ready_q, cmd_ready_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [IGN_CNT_W-1:0] ign_cnt_q, ign_cnt_d;
  logic [WIDTH-1:0]     rd_data_q, rd_data_d;

  assign accept = cmd_valid & cmd_ready_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign addr_hit[gi] = (cmd_addr == AW'(gi));

    force_bank_entry #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel        (accept & addr_hit[gi]),
      .op         (cmd_op),
      .data       (cmd_data),
      .value      (value_vec[gi]),
      .value_next (value_next[gi]),
      .forced     (forced_mask[gi]),
      .drop_pulse (drop_vec[gi]),
      .err_pulse  (err_vec[gi])
    );
  end

  always_comb begin
    // Any accepted RELEASE (even an erroring one) stalls the port for a cycle.
    cmd_ready_d = !(accept && (op_e'(cmd_op) == OP_RELEASE));
    // An address matching no entry is flagged regardless of opcode.
    cmd_err_d   = accept && (!(|addr_hit) || (|err_vec));

    ign_cnt_d = ign_cnt_q;
    if ((|drop_vec) && (ign_cnt_q != {IGN_CNT_W{1'b1}}))
      ign_cnt_d = ign_cnt_q + IGN_CNT_W'(1);

    // Read the post-edge value so a write on the same edge is visible.
    rd_data_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) rd_data_d = value_next[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q <= 1'b1;
      cmd_err_q   <= 1'b0;
      ign_cnt_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
      ign_cnt_q   <= ign_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_err   = cmd_err_q;
  assign ign_cnt   = ign_cnt_q;
  assign rd_data   = rd_data_q;

endmodule
